// File: rtl/spi_byte_master.sv
// SPI mode-0 byte shift engine: MSB-first transmit on mosi, capture of miso on rising sck.
// The control unit owns nCS; this block only reports spi_busy / byte_done.
module spi_byte_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_data,
   input  logic [7:0] tx_data,
   input  logic       miso,
   output logic       spi_busy,
   output logic       byte_done,
   output logic [7:0] rx_data,
   output logic       sck,
   output logic       mosi
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCK_LO = 2'd1,
      SCK_HI = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_r;
   logic [6:0] tx_sr_r;   // bit 7 goes straight to mosi on acceptance, only the tail is kept
   logic [7:0] rx_sr_r;
   logic [7:0] div_r;
   logic [2:0] bit_r;

   // Transfer sequencer; every output is driven from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         tx_sr_r   <= 7'h00;
         rx_sr_r   <= 8'h00;
         div_r     <= 8'h00;
         bit_r     <= 3'd0;
         spi_busy  <= 1'b0;
         byte_done <= 1'b0;
         rx_data   <= 8'h00;
         sck       <= 1'b0;
         mosi      <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         case (state_r)
            IDLE: begin
               sck <= 1'b0;
               if (load_data) begin
                  tx_sr_r  <= tx_data[6:0];
                  mosi     <= tx_data[7];
                  spi_busy <= 1'b1;
                  div_r    <= 8'h00;
                  bit_r    <= 3'd0;
                  state_r  <= SCK_LO;
               end else begin
                  mosi     <= 1'b0;
                  spi_busy <= 1'b0;
               end
            end
            SCK_LO: begin
               if (div_r == DIV_LAST) begin
                  sck     <= 1'b1;
                  rx_sr_r <= {rx_sr_r[6:0], miso};
                  div_r   <= 8'h00;
                  state_r <= SCK_HI;
               end else begin
                  div_r <= div_r + 8'd1;
               end
            end
            SCK_HI: begin
               if (div_r == DIV_LAST) begin
                  sck   <= 1'b0;
                  div_r <= 8'h00;
                  // mosi only moves on the falling edge so the slave sees stable data at rise
                  if (bit_r == 3'd7) begin
                     state_r <= DONE;
                  end else begin
                     tx_sr_r <= {tx_sr_r[5:0], 1'b0};
                     mosi    <= tx_sr_r[6];
                     bit_r   <= bit_r + 3'd1;
                     state_r <= SCK_LO;
                  end
               end else begin
                  div_r <= div_r + 8'd1;
               end
            end
            DONE: begin
               spi_busy  <= 1'b0;
               byte_done <= 1'b1;
               rx_data   <= rx_sr_r;
               mosi      <= 1'b0;
               sck       <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               spi_busy <= 1'b0;
               sck      <= 1'b0;
               mosi     <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: one CLK_DIV=4 instance with switchable miso, one CLK_DIV=1 in loopback.
module tb_spi_byte_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       load4, load1;
   logic [7:0] tx4, tx1;
   logic       miso4, miso1;
   logic       busy4, done4, sck4, mosi4;
   logic       busy1, done1, sck1, mosi1;
   logic [7:0] rx4, rx1;
   logic [1:0] miso_mode;

   int vectors = 0;
   int miscompares = 0;

   int         rises, hi_run, lo_run, width_err, mosi_err, busy_cnt, done_cnt, done_busy_err;
   int         done_idx [2];
   logic [7:0] rx_at_done [2];
   logic [7:0] mosi_bits;
   logic       mosi_or, prev_sck, prev_busy, prev_mosi;
   logic       activity;
   int         busy1_cnt, done1_cnt, done4_cnt;

   always #5 clk = ~clk;

   assign miso4 = (miso_mode == 2'd0) ? mosi4 : (miso_mode == 2'd1);
   assign miso1 = mosi1;

   spi_byte_master #(.CLK_DIV(4)) u_dut4 (
      .clk(clk), .reset(reset), .load_data(load4), .tx_data(tx4), .miso(miso4),
      .spi_busy(busy4), .byte_done(done4), .rx_data(rx4), .sck(sck4), .mosi(mosi4)
   );

   spi_byte_master #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .load_data(load1), .tx_data(tx1), .miso(miso1),
      .spi_busy(busy1), .byte_done(done1), .rx_data(rx1), .sck(sck1), .mosi(mosi1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      rises = 0; hi_run = 0; lo_run = 0; width_err = 0; mosi_err = 0;
      busy_cnt = 0; done_cnt = 0; done_busy_err = 0;
      done_idx[0] = -1; done_idx[1] = -1;
      rx_at_done[0] = 8'h00; rx_at_done[1] = 8'h00;
      mosi_bits = 8'h00; mosi_or = 1'b0;
      prev_sck = sck4; prev_busy = busy4; prev_mosi = mosi4;
   endtask

   // Per-cycle observation of the CLK_DIV=4 instance (4 high / 4 low sck phases).
   task automatic mon(input int i);
      if (sck4 && !prev_sck) begin
         if (lo_run != 4) width_err++;
         rises++;
         mosi_bits = {mosi_bits[6:0], mosi4};
      end
      if (!sck4 && prev_sck && hi_run != 4) width_err++;
      if (sck4) begin
         hi_run++;
         lo_run = 0;
      end else begin
         hi_run = 0;
         lo_run = busy4 ? lo_run + 1 : 0;
      end
      if (busy4 && prev_busy && (mosi4 !== prev_mosi) && !(prev_sck && !sck4)) mosi_err++;
      mosi_or = mosi_or | mosi4;
      busy_cnt += int'(busy4);
      if (done4) begin
         if (busy4) done_busy_err++;
         if (done_cnt < 2) begin
            done_idx[done_cnt]   = i;
            rx_at_done[done_cnt] = rx4;
         end
         done_cnt++;
      end
      prev_sck = sck4; prev_busy = busy4; prev_mosi = mosi4;
   endtask

   // Load d, optionally re-strobe load_data with d2 at step mid_at, then observe nsteps cycles.
   task automatic run4(input logic [7:0] d, input int mid_at, input logic [7:0] d2, input int nsteps);
      clr_mon();
      load4 = 1'b1;
      tx4   = d;
      for (int i = 0; i < nsteps; i++) begin
         @(posedge clk); #1;
         mon(i);
         if (i == mid_at) begin
            load4 = 1'b1;
            tx4   = d2;
         end else begin
            load4 = 1'b0;
            tx4   = ~d;
         end
      end
   endtask

   initial begin
      reset = 1'b0; load4 = 1'b0; load1 = 1'b0; tx4 = 8'h00; tx1 = 8'h00; miso_mode = 2'd0;

      // 1: reset and quiet idle
      repeat (5) @(posedge clk);
      #1;
      check("rst_busy", busy4, 1'b0);
      check("rst_done", done4, 1'b0);
      check("rst_sck", sck4, 1'b0);
      check("rst_mosi", mosi4, 1'b0);
      check("rst_rx", rx4, 8'h00);
      reset = 1'b1;
      activity = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         activity = activity | busy4 | done4 | sck4 | mosi4 | busy1 | done1 | sck1 | mosi1;
      end
      check("idle_quiet", activity, 1'b0);
      check("idle_rx", rx4, 8'h00);

      // 2: loopback A5
      run4(8'hA5, -1, 8'h00, 75);
      check("a5_mosi", mosi_bits, 8'hA5);
      check("a5_rises", rises, 8);
      check("a5_width", width_err, 0);
      check("a5_mosi_edge", mosi_err, 0);
      check("a5_busy_cnt", busy_cnt, 65);
      check("a5_done_cnt", done_cnt, 1);
      check("a5_done_idx", done_idx[0], 65);
      check("a5_done_busy", done_busy_err, 0);
      check("a5_rx", rx4, 8'hA5);

      // 3: miso forced high / low
      miso_mode = 2'd1;
      run4(8'h00, -1, 8'h00, 75);
      check("hi_mosi_or", mosi_or, 1'b0);
      check("hi_rx", rx4, 8'hFF);
      miso_mode = 2'd2;
      run4(8'hFF, -1, 8'h00, 75);
      check("lo_mosi", mosi_bits, 8'hFF);
      check("lo_rx", rx4, 8'h00);
      miso_mode = 2'd0;

      // 4: load during transfer is ignored
      run4(8'h3C, 20, 8'hC3, 75);
      check("ign_mosi", mosi_bits, 8'h3C);
      check("ign_rx", rx4, 8'h3C);
      check("ign_done_cnt", done_cnt, 1);
      check("ign_busy_cnt", busy_cnt, 65);
      check("ign_idle_busy", busy4, 1'b0);
      check("ign_idle_sck", sck4, 1'b0);

      // 5: back-to-back load in the byte_done cycle
      run4(8'h12, 65, 8'h34, 140);
      check("b2b_done_cnt", done_cnt, 2);
      check("b2b_rx0", rx_at_done[0], 8'h12);
      check("b2b_rx1", rx_at_done[1], 8'h34);
      check("b2b_gap", done_idx[1] - done_idx[0], 66);
      check("b2b_busy_cnt", busy_cnt, 130);
      check("b2b_rx_end", rx4, 8'h34);

      // 6: async reset in bit 3 of 5A, then CLK_DIV=1 transfer
      load4 = 1'b1;
      tx4   = 8'h5A;
      for (int i = 0; i <= 28; i++) begin
         @(posedge clk); #1;
         load4 = 1'b0;
      end
      check("mid_busy_pre", busy4, 1'b1);
      check("mid_sck_pre", sck4, 1'b1);
      check("mid_mosi_pre", mosi4, 1'b1);
      #3;
      reset = 1'b0;
      #1;
      check("mid_busy_rst", busy4, 1'b0);
      check("mid_sck_rst", sck4, 1'b0);
      check("mid_mosi_rst", mosi4, 1'b0);
      check("mid_rx_rst", rx4, 8'h00);
      check("mid_done_rst", done4, 1'b0);
      done4_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         done4_cnt += int'(done4);
      end
      reset = 1'b1;
      load1 = 1'b1;
      tx1   = 8'h81;
      busy1_cnt = 0;
      done1_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         load1 = 1'b0;
         tx1   = 8'h00;
         busy1_cnt += int'(busy1);
         done1_cnt += int'(done1);
         done4_cnt += int'(done4);
      end
      check("rst_no_done", done4_cnt, 0);
      check("div1_busy_cnt", busy1_cnt, 17);
      check("div1_done_cnt", done1_cnt, 1);
      check("div1_rx", rx1, 8'h81);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
